phase_accumulator: RTL and testbench

Parametrised N-bit phase accumulator, the successor to the fixed 4-bit `counter` in the DDS datapath. It advances by a programmable frequency tuning word (FTW) each enabled cycle and applies a phase offset. It emits a truncated, registered phase word for the downstream phase-to-amplitude lookup. New FTWs load through a valid/ready handshake and take effect either immediately or at the next accumulator wrap, which gives glitch-free frequency hops.

---
 rtl/dds_pkg.sv | 13 +
 rtl/ftw_shadow.sv | 68 ++++++
 rtl/phase_accumulator.sv | 82 ++++++++
 tb/tb_phase_accumulator.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS phase datapath.
// Default widths and the FTW shadow-register state type.
package dds_pkg;

    localparam int ACC_WIDTH_DEF = 32;
    localparam int OUT_WIDTH_DEF = 12;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } ftw_state_t;

endpackage

// File: rtl/ftw_shadow.sv
// Double-buffered tuning word with valid/ready load handshake.
// Pending word is applied on the next edge or on the next accumulator wrap.
module ftw_shadow
    import dds_pkg::*;
#(
    parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ACC_WIDTH-1:0] ftw,
    input  logic                 ftw_valid,
    output logic                 ftw_ready,
    input  logic                 update_on_wrap,
    input  logic                 carry,
    input  logic                 enable,
    input  logic                 sync_clear,
    output logic [ACC_WIDTH-1:0] ftw_active
);

    ftw_state_t           state;
    ftw_state_t           state_next;
    logic [ACC_WIDTH-1:0] ftw_pending;
    logic                 load_pending;
    logic                 apply;
    logic                 wrap_now;

    // A cleared cycle never counts as a wrap, even if the add would carry.
    assign wrap_now = carry && enable && !sync_clear;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ftw_pending <= '0;
            ftw_active  <= '0;
        end else begin
            state <= state_next;
            if (load_pending) begin
                ftw_pending <= ftw;
            end
            if (apply) begin
                ftw_active <= ftw_pending;
            end
        end
    end

    always_comb begin
        state_next   = state;
        load_pending = 1'b0;
        apply        = 1'b0;
        ftw_ready    = 1'b0;
        unique case (state)
            IDLE: begin
                ftw_ready = 1'b1;
                if (ftw_valid) begin
                    load_pending = 1'b1;
                    state_next   = PENDING;
                end
            end
            PENDING: begin
                if (!update_on_wrap || wrap_now) begin
                    apply      = 1'b1;
                    state_next = IDLE;
                end
            end
        endcase
    end

endmodule

// File: rtl/phase_accumulator.sv
// N-bit DDS phase accumulator with programmable FTW and phase offset.
// Emits a truncated, registered phase word two cycles after enable.
module phase_accumulator
    import dds_pkg::*;
#(
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 sync_clear,
    input  logic [ACC_WIDTH-1:0] ftw,
    input  logic                 ftw_valid,
    output logic                 ftw_ready,
    input  logic                 update_on_wrap,
    input  logic [ACC_WIDTH-1:0] phase_offset,
    output logic [OUT_WIDTH-1:0] phase_out,
    output logic                 phase_valid,
    output logic                 wrap
);

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] ftw_active;
    logic [ACC_WIDTH-1:0] offset_phase;
    logic [ACC_WIDTH:0]   sum;
    logic                 carry;
    logic                 carry_q;
    logic                 en_q;

    assign sum          = {1'b0, acc} + {1'b0, ftw_active};
    assign carry        = sum[ACC_WIDTH];
    assign offset_phase = acc + phase_offset;

    ftw_shadow #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_shadow (
        .clk            (clk),
        .reset          (reset),
        .ftw            (ftw),
        .ftw_valid      (ftw_valid),
        .ftw_ready      (ftw_ready),
        .update_on_wrap (update_on_wrap),
        .carry          (carry),
        .enable         (enable),
        .sync_clear     (sync_clear),
        .ftw_active     (ftw_active)
    );

    // carry_q only marks enabled overflowing steps, so wrap stays one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc     <= '0;
            carry_q <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            en_q <= enable && !sync_clear;
            if (sync_clear) begin
                acc     <= '0;
                carry_q <= 1'b0;
            end else if (enable) begin
                acc     <= sum[ACC_WIDTH-1:0];
                carry_q <= carry;
            end else begin
                carry_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_out   <= '0;
            phase_valid <= 1'b0;
            wrap        <= 1'b0;
        end else begin
            phase_out   <= offset_phase[ACC_WIDTH-1 -: OUT_WIDTH];
            phase_valid <= en_q;
            wrap        <= carry_q;
        end
    end

endmodule

// File: tb/tb_phase_accumulator.sv
// Self-checking bench for phase_accumulator (ACC_WIDTH=8, OUT_WIDTH=4).
// Directed table, hand sequences, then random stimulus against a model.
module tb_phase_accumulator;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       sync_clear = 1'b0;
    logic [7:0] ftw = '0;
    logic       ftw_valid = 1'b0;
    logic       ftw_ready;
    logic       update_on_wrap = 1'b0;
    logic [7:0] phase_offset = '0;
    logic [3:0] phase_out;
    logic       phase_valid;
    logic       wrap;

    int checks = 0;
    int failures = 0;

    // Reference model state (plain integer arithmetic).
    int m_acc;
    int m_active;
    int m_pend;
    bit m_pv;
    bit m_cs;
    bit m_es;
    int e_phase;
    bit e_valid;
    bit e_wrap;

    typedef struct {
        logic       en;
        logic       fv;
        logic [7:0] word;
        int         phase;
        logic       valid;
        logic       wrp;
        logic       rdy;
    } vec_t;

    vec_t tbl[20];

    phase_accumulator #(
        .ACC_WIDTH (8),
        .OUT_WIDTH (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .sync_clear     (sync_clear),
        .ftw            (ftw),
        .ftw_valid      (ftw_valid),
        .ftw_ready      (ftw_ready),
        .update_on_wrap (update_on_wrap),
        .phase_offset   (phase_offset),
        .phase_out      (phase_out),
        .phase_valid    (phase_valid),
        .wrap           (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_acc = 0;
        m_active = 0;
        m_pend = 0;
        m_pv = 0;
        m_cs = 0;
        m_es = 0;
        e_phase = 0;
        e_valid = 0;
        e_wrap = 0;
    endtask

    task automatic model_step();
        int sum;
        bit ovf;
        if (!reset) begin
            model_reset();
            return;
        end
        e_phase = ((m_acc + int'(phase_offset)) % 256) / 16;
        e_wrap = m_cs;
        e_valid = m_es;
        sum = m_acc + m_active;
        ovf = enable && !sync_clear && (sum > 255);
        if (m_pv) begin
            if (!update_on_wrap || ovf) begin
                m_active = m_pend;
                m_pv = 0;
            end
        end else if (ftw_valid) begin
            m_pend = int'(ftw);
            m_pv = 1;
        end
        if (sync_clear) m_acc = 0;
        else if (enable) m_acc = sum % 256;
        m_cs = ovf;
        m_es = enable && !sync_clear;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_in(input logic en, input logic clr, input logic fv,
                          input logic [7:0] w, input logic uow,
                          input logic [7:0] off);
        enable = en;
        sync_clear = clr;
        ftw_valid = fv;
        ftw = w;
        update_on_wrap = uow;
        phase_offset = off;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 8'h00, 0, 8'h00);
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic load_now(input logic [7:0] w);
        set_in(0, 0, 1, w, 0, 8'h00);
        tick();
        set_in(0, 0, 0, 8'h00, 0, 8'h00);
        tick();
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, "_phase"}, int'(phase_out), e_phase);
        chk({tag, "_valid"}, int'(phase_valid), int'(e_valid));
        chk({tag, "_wrap"}, int'(wrap), int'(e_wrap));
        chk({tag, "_ready"}, int'(ftw_ready), int'(!m_pv));
    endtask

    initial begin
        model_reset();

        // Reset held with random inputs.
        for (int i = 0; i < 4; i++) begin
            set_in($urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 1), 8'($urandom()),
                   $urandom_range(0, 1), 8'($urandom()));
            @(posedge clk);
            #1;
            chk("rst_phase", int'(phase_out), 0);
            chk("rst_valid", int'(phase_valid), 0);
            chk("rst_wrap", int'(wrap), 0);
            chk("rst_ready", int'(ftw_ready), 1);
        end
        set_in(0, 0, 0, 8'h00, 0, 8'h00);
        reset = 1'b1;

        // No FTW loaded: phase never moves.
        set_in(1, 0, 0, 8'h00, 0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("zero_ftw_phase", int'(phase_out), 0);
            chk("zero_ftw_wrap", int'(wrap), 0);
        end

        // Immediate load of 0x10, then run across one wrap.
        tbl[0] = '{en: 0, fv: 1, word: 8'h10, phase: 0, valid: 0, wrp: 0, rdy: 0};
        tbl[1] = '{en: 0, fv: 0, word: 8'h00, phase: 0, valid: 0, wrp: 0, rdy: 1};
        tbl[2] = '{en: 1, fv: 0, word: 8'h00, phase: 0, valid: 0, wrp: 0, rdy: 1};
        for (int r = 3; r < 20; r++) begin
            tbl[r] = '{en: 1, fv: 0, word: 8'h00, phase: (r - 2) % 16,
                       valid: 1, wrp: (r == 18), rdy: 1};
        end
        do_reset();
        for (int r = 0; r < 20; r++) begin
            set_in(tbl[r].en, 0, tbl[r].fv, tbl[r].word, 0, 8'h00);
            tick();
            chk($sformatf("tbl%0d_phase", r), int'(phase_out), tbl[r].phase);
            chk($sformatf("tbl%0d_valid", r), int'(phase_valid), int'(tbl[r].valid));
            chk($sformatf("tbl%0d_wrap", r), int'(wrap), int'(tbl[r].wrp));
            chk($sformatf("tbl%0d_ready", r), int'(ftw_ready), int'(tbl[r].rdy));
        end

        // Non-dividing FTW 0x30.
        begin
            int exp_ph[6] = '{3, 6, 9, 12, 15, 2};
            int exp_wr[6] = '{0, 0, 0, 0, 0, 1};
            do_reset();
            load_now(8'h30);
            set_in(1, 0, 0, 8'h00, 0, 8'h00);
            tick();
            for (int j = 0; j < 6; j++) begin
                if (j == 5) enable = 1'b0;
                tick();
                chk($sformatf("nd%0d_phase", j), int'(phase_out), exp_ph[j]);
                chk($sformatf("nd%0d_wrap", j), int'(wrap), exp_wr[j]);
            end
        end

        // Wrap-mode hop 0x40 -> 0x80 with a held second word 0x55.
        do_reset();
        load_now(8'h40);
        set_in(1, 0, 0, 8'h00, 0, 8'h00);
        tick();
        set_in(1, 0, 1, 8'h80, 1, 8'h00);
        tick();
        chk("hopA_phase", int'(phase_out), 4);
        chk("hopA_ready", int'(ftw_ready), 0);
        set_in(1, 0, 1, 8'h55, 1, 8'h00);
        tick();
        chk("hopB_phase", int'(phase_out), 8);
        chk("hopB_ready", int'(ftw_ready), 0);
        tick();
        chk("hopC_phase", int'(phase_out), 12);
        chk("hopC_ready", int'(ftw_ready), 1);
        tick();
        chk("hopD_phase", int'(phase_out), 0);
        chk("hopD_wrap", int'(wrap), 1);
        chk("hopD_ready", int'(ftw_ready), 0);
        set_in(1, 0, 0, 8'h00, 1, 8'h00);
        tick();
        chk("hopE_phase", int'(phase_out), 8);
        chk("hopE_wrap", int'(wrap), 0);
        chk("hopE_ready", int'(ftw_ready), 1);
        tick();
        chk("hopF_phase", int'(phase_out), 0);
        chk("hopF_wrap", int'(wrap), 1);
        enable = 1'b0;
        tick();
        chk("hopG_phase", int'(phase_out), 5);
        chk("hopG_wrap", int'(wrap), 0);

        // Clear with offset; pending wrap-mode word survives the clear.
        do_reset();
        load_now(8'h10);
        set_in(1, 0, 0, 8'h00, 0, 8'h00);
        repeat (7) tick();
        set_in(0, 0, 1, 8'h20, 1, 8'h00);
        tick();
        chk("clr_pend_ready", int'(ftw_ready), 0);
        set_in(1, 1, 0, 8'h00, 1, 8'h00);
        tick();
        set_in(0, 0, 0, 8'h00, 1, 8'h80);
        tick();
        chk("clr_phase", int'(phase_out), 8);
        chk("clr_wrap", int'(wrap), 0);
        chk("clr_valid", int'(phase_valid), 0);
        chk("clr_ready", int'(ftw_ready), 0);
        set_in(1, 0, 0, 8'h00, 1, 8'h00);
        repeat (15) tick();
        chk("clr_hold_ready", int'(ftw_ready), 0);
        tick();
        chk("clr_apply_ready", int'(ftw_ready), 1);
        tick();
        chk("clr_apply_wrap", int'(wrap), 1);
        tick();
        chk("clr_new_ftw_phase", int'(phase_out), 2);

        // Random stimulus against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b0;
                model_reset();
                #1;
                cmp_model("rnd_rst");
                @(posedge clk);
                #1;
                reset = 1'b1;
            end else begin
                set_in($urandom_range(0, 3) != 0,
                       $urandom_range(0, 15) == 0,
                       $urandom_range(0, 3) == 0,
                       ($urandom_range(0, 3) == 0) ? 8'($urandom_range(128, 255))
                                                   : 8'($urandom()),
                       $urandom_range(0, 1),
                       8'($urandom()));
                tick();
                cmp_model("rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
